// File: rtl/seawolf_sample_fetch_arbiter.sv
// Round-robin arbiter and sequencer for the shared sample-memory read port.
// One read is in flight at a time. The sequence is grant (IDLE), strobe (ISSUE),
// then completion (WAIT). Completion comes from s_ready, or after a fixed latency.
module seawolf_sample_fetch_arbiter #(
    parameter int NV        = 4,
    parameter int AW        = 24,
    parameter int FIXED_LAT = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              s_enable,
    input  logic [NV-1:0]     v_req,
    input  logic [NV*AW-1:0]  v_addr,
    output logic [NV-1:0]     v_ack,
    output logic [15:0]       v_data,
    output logic [NV-1:0]     v_valid,
    output logic              v_err,
    output logic [AW-1:0]     s_addr,
    output logic              s_read,
    input  logic [15:0]       s_data,
    input  logic              s_ready,
    output logic              busy
);

    localparam int IW   = (NV > 1) ? $clog2(NV) : 1;
    localparam int CMAX = (TIMEOUT > FIXED_LAT) ? ((TIMEOUT > 1) ? TIMEOUT : 1)
                                                : ((FIXED_LAT > 1) ? FIXED_LAT : 1);
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   rr_ptr, rr_nx, gnt, gnt_nx, rr_inc;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [AW-1:0]   addr_nx;
    logic [15:0]     data_nx;
    logic [NV-1:0]   valid_nx;
    logic            err_nx;
    logic            found;
    logic [IW-1:0]   pick;
    logic [IW:0]     sum;
    logic [AW-1:0]   addr_arr [NV];

    for (genvar i = 0; i < NV; i++) begin : g_addr
        assign addr_arr[i] = v_addr[i*AW +: AW];
    end

    assign busy   = (state != IDLE);
    assign rr_inc = (gnt == IW'(NV-1)) ? '0 : gnt + 1'b1;

    // Pick the first requester at or after rr_ptr, wrapping modulo NV.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        for (int k = 0; k < NV; k++) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(NV)) sum = sum - (IW+1)'(NV);
            if (!found && v_req[sum[IW-1:0]]) begin
                found = 1'b1;
                pick  = sum[IW-1:0];
            end
        end
    end

    // Next-state and output decode. The grant is suppressed while RESET is high
    // so that a voice never sees an ack for a transaction that reset wipes out.
    always_comb begin
        state_nx = state;
        rr_nx    = rr_ptr;
        gnt_nx   = gnt;
        cnt_nx   = cnt;
        addr_nx  = s_addr;
        data_nx  = v_data;
        valid_nx = '0;
        err_nx   = 1'b0;
        v_ack    = '0;
        s_read   = 1'b0;
        case (state)
            IDLE: begin
                if (s_enable && found && !RESET) begin
                    gnt_nx      = pick;
                    addr_nx     = addr_arr[pick];
                    v_ack[pick] = 1'b1;
                    state_nx    = ISSUE;
                end
            end
            ISSUE: begin
                s_read   = 1'b1;
                cnt_nx   = (FIXED_LAT > 0) ? CW'(FIXED_LAT - 1) : '0;
                state_nx = WAIT;
            end
            WAIT: begin
                if (FIXED_LAT > 0) begin
                    if (cnt == '0) begin
                        data_nx       = s_data;
                        valid_nx[gnt] = 1'b1;
                        rr_nx         = rr_inc;
                        state_nx      = IDLE;
                    end else begin
                        cnt_nx = cnt - 1'b1;
                    end
                end else if (s_ready) begin
                    // s_ready on the final allowed cycle still counts as success.
                    data_nx       = s_data;
                    valid_nx[gnt] = 1'b1;
                    rr_nx         = rr_inc;
                    state_nx      = IDLE;
                end else if ((TIMEOUT > 0) && (cnt == CW'(TIMEOUT - 1))) begin
                    data_nx       = '0;
                    valid_nx[gnt] = 1'b1;
                    err_nx        = 1'b1;
                    rr_nx         = rr_inc;
                    state_nx      = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and datapath registers. Reset discards any in-flight read.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            gnt     <= '0;
            cnt     <= '0;
            s_addr  <= '0;
            v_data  <= '0;
            v_valid <= '0;
            v_err   <= 1'b0;
        end else begin
            state   <= state_nx;
            rr_ptr  <= rr_nx;
            gnt     <= gnt_nx;
            cnt     <= cnt_nx;
            s_addr  <= addr_nx;
            v_data  <= data_nx;
            v_valid <= valid_nx;
            v_err   <= err_nx;
        end
    end

endmodule

// File: doc/seawolf_sample_fetch_arbiter.md
Name: seawolf_sample_fetch_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single sample-memory read port among NV independent sample voices (s_addr/s_read/s_data/s_ready).
- The port is served by SDRAM when the frame buffer is used, and by DDRAM otherwise.
- Sits between the per-voice sample players and the memory-port glue.
- Issues one read at a time, waits for completion (handshake or fixed latency), returns the word to the granted voice, then rotates priority.

Parameters:
- NV, 4, number of voice requesters (2..8).
- AW, 24, sample-memory address width.
- FIXED_LAT, 0: 0 = completion on s_ready; N>0 = s_data valid exactly N cycles after the s_read pulse, s_ready ignored.
- TIMEOUT, 255: max WAIT cycles before abort in handshake mode; 0 disables the timeout.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- s_enable  in  1  sample memory available; gates new grants only.
- v_req  in  NV  per-voice read request, level; held until v_ack.
- v_addr  in  NV*AW  per-voice word address; voice i at bits [i*AW +: AW].
- v_ack  out  NV  one-hot, one-cycle grant pulse; address captured this cycle.
- v_data  out  16  returned sample word, shared by all voices.
- v_valid  out  NV  one-hot, one-cycle pulse; v_data valid for that voice.
- v_err  out  1  one-cycle pulse on timeout abort.
- s_addr  out  AW  memory address.
- s_read  out  1  memory read strobe, one-cycle pulse.
- s_data  in  16  memory read data.
- s_ready  in  1  memory completion, handshake mode only.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (RESET=1 at a CLK edge): state=IDLE, rr_ptr=0, grant index=0, wait counter=0.
- All outputs read 0 on reset: v_ack, v_valid, v_err, s_read, s_addr, v_data, busy.
- Reset overrides any in-flight transaction; no v_valid is ever produced for it, and late s_ready/s_data are ignored.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If s_enable=1 and v_req!=0, grant g = first set bit of v_req scanning from rr_ptr upward, modulo NV.
  - At the same edge: latch s_addr<=v_addr[g], pulse v_ack[g], go to ISSUE.
  - Otherwise stay in IDLE; s_addr holds its last value.
- ISSUE:
  - s_read=1 for exactly this one cycle; s_addr stable.
  - Load the wait counter: FIXED_LAT-1 in fixed mode, 0 in handshake mode. Go to WAIT.
  - s_ready is not sampled in ISSUE.
- WAIT, handshake mode (FIXED_LAT=0):
  - On the first cycle with s_ready=1: v_data<=s_data, pulse v_valid[g], rr_ptr<=(g+1) mod NV, go to IDLE.
  - If TIMEOUT>0 and the counter reaches TIMEOUT without s_ready: v_data<=0, pulse v_valid[g] and v_err, rotate rr_ptr, go to IDLE.
  - s_ready arriving on the timeout cycle wins; no v_err in that case.
- WAIT, fixed mode (FIXED_LAT>0):
  - Count down; when the counter reaches 0, capture s_data at that edge and complete as in handshake mode.
  - Result: s_data is sampled FIXED_LAT cycles after the s_read cycle.
- Latency, idle to data: grant edge, ISSUE cycle, then WAIT.
  - Handshake mode: v_valid is high the cycle after s_ready is sampled.
  - Fixed mode: v_valid is high FIXED_LAT+1 cycles after the s_read cycle.
- Back-to-back: the completion cycle returns to IDLE, so a new grant occurs the next cycle at the earliest. Max one outstanding read.
- s_enable low during ISSUE/WAIT does not abort the transaction; it only blocks the next grant.
- A voice dropping v_req before its v_ack is never granted; changes to v_req/v_addr after v_ack do not affect the transaction.
- A voice re-requesting during its own WAIT gets lower priority than the others on the next arbitration (rotation).
- Simultaneous requests from all voices: service order is rr_ptr, rr_ptr+1, ...; no starvation.
  - Bound: every requesting voice is acked within NV transactions.
- rr_ptr wraps from NV-1 to 0.
- v_data holds its last value between completions.

Test Plan:
- Reset, FIXED_LAT=0: v_req=4'b0001, v_addr0=24'h000100, s_ready pulsed 3 cycles after s_read with s_data=16'hA5A5.
  - Required: v_ack=0001 on the grant edge, s_read one cycle with s_addr=000100.
  - Required: v_valid=0001 and v_data=A5A5 the cycle after s_ready; busy=0 afterwards.
- All four voices request continuously, ready after 2 cycles: ack order 0,1,2,3,0.
  - Required: no v_ack while busy; exactly one s_read per transaction.
- TIMEOUT=8, no s_ready: v_valid[g]=1, v_err=1, v_data=0000 exactly 8 WAIT cycles after entering WAIT.
  - Required: next grant goes to voice g+1.
- FIXED_LAT=4, s_data changes every cycle: captured v_data equals the s_data present 4 cycles after s_read; s_ready toggling has no effect.
- RESET asserted during WAIT, then s_ready=1: all outputs 0, no v_valid ever pulses, next grant returns to voice 0 (rr_ptr=0).
- s_enable=0 with v_req=1111: no v_ack. s_enable dropped mid-WAIT: the transaction still completes, and no new grant until s_enable=1.
